// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble.
// One shift/adjust iteration per clock. Valid/ready handshakes on both sides.
module bcd2bin_seq #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned W      = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W-1:0]          bin,
    output logic                  err
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [BW-1:0]   bcd_r;
    logic [W-1:0]    bin_r;
    logic [CW-1:0]   count;
    logic            err_r;
    logic            bad_digit;
    logic            last_iter;
    logic [BW-1:0]   bcd_sh;
    logic [BW-1:0]   bcd_adj;
    logic [W-1:0]    bin_sh;

    assign last_iter = (count == CW'(W - 1));
    assign bin       = bin_r;
    assign err       = err_r;

    // Flag any input nibble outside 0..9.
    always_comb begin
        bad_digit = 1'b0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (bcd[4*d +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    // One reverse double-dabble step: shift right, then subtract 3 from digits >= 8.
    always_comb begin
        bcd_sh  = {1'b0, bcd_r[BW-1:1]};
        bin_sh  = {bcd_r[0], bin_r[W-1:1]};
        bcd_adj = bcd_sh;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (bcd_sh[4*d +: 4] >= 4'd8) begin
                bcd_adj[4*d +: 4] = bcd_sh[4*d +: 4] - 4'd3;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid) begin
                    state_nx = bad_digit ? DONE : CONV;
                end
            end
            CONV: begin
                if (last_iter) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: load on accept, iterate in CONV, hold result otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_r <= '0;
            bin_r <= '0;
            count <= '0;
            err_r <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        count <= '0;
                        bin_r <= '0;
                        if (bad_digit) begin
                            bcd_r <= '0;
                            err_r <= 1'b1;
                        end else begin
                            bcd_r <= bcd;
                            err_r <= 1'b0;
                        end
                    end
                end
                CONV: begin
                    bcd_r <= bcd_adj;
                    bin_r <= bin_sh;
                    count <= last_iter ? '0 : count + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq at DIGITS=4/W=14 and DIGITS=2/W=7.
module tb_bcd2bin_seq;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid4, in_ready4, out_valid4, out_ready4, err4;
    logic [15:0] bcd4;
    logic [13:0] bin4;

    logic        in_valid2, in_ready2, out_valid2, out_ready2, err2;
    logic [7:0]  bcd2;
    logic [6:0]  bin2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bcd2bin_seq #(.DIGITS(4), .W(14)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .bcd       (bcd4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .bin       (bin4),
        .err       (err4)
    );

    bcd2bin_seq #(.DIGITS(2), .W(7)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .bcd       (bcd2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .bin       (bin2),
        .err       (err2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Decimal value of a packed BCD word; any nibble above 9 makes it an error with value 0.
    task automatic ref_conv(input logic [31:0] w, input int nd,
                            output int unsigned val, output bit bad);
        logic [31:0] tmp;
        int unsigned d;
        val = 0;
        bad = 1'b0;
        for (int i = nd - 1; i >= 0; i--) begin
            tmp = w >> (4 * i);
            d   = int'(tmp & 32'hF);
            if (d > 9) bad = 1'b1;
            val = val * 10 + d;
        end
        if (bad) val = 0;
    endtask

    task automatic send4(input logic [15:0] w, input int unsigned stall, input bit scramble);
        int unsigned exp_val;
        bit          exp_err;
        int unsigned lat;
        ref_conv(32'(w), 4, exp_val, exp_err);
        @(negedge clk);
        bcd4      = w;
        in_valid4 = 1'b1;
        check("in_ready_idle4", 32'(in_ready4), 32'd1);
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        if (scramble) bcd4 = 16'($urandom);
        check("in_ready_busy4", 32'(in_ready4), 32'd0);
        lat = 0;
        while (!out_valid4 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency4", lat, exp_err ? 32'd0 : 32'd14);
        check("bin4", 32'(bin4), exp_val);
        check("err4", 32'(err4), 32'(exp_err));
        repeat (stall) begin
            @(posedge clk);
            #1;
            check("hold_valid4", 32'(out_valid4), 32'd1);
            check("hold_bin4", 32'(bin4), exp_val);
            check("hold_ready4", 32'(in_ready4), 32'd0);
        end
        out_ready4 = 1'b1;
        @(posedge clk);
        #1;
        out_ready4 = 1'b0;
        check("valid_clear4", 32'(out_valid4), 32'd0);
        check("in_ready_back4", 32'(in_ready4), 32'd1);
        check("bin_keep4", 32'(bin4), exp_val);
    endtask

    task automatic send2(input logic [7:0] w);
        int unsigned exp_val;
        bit          exp_err;
        int unsigned lat;
        ref_conv(32'(w), 2, exp_val, exp_err);
        @(negedge clk);
        bcd2      = w;
        in_valid2 = 1'b1;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        lat = 0;
        while (!out_valid2 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency2", lat, exp_err ? 32'd0 : 32'd7);
        check("bin2", 32'(bin2), exp_val);
        check("err2", 32'(err2), 32'(exp_err));
        out_ready2 = 1'b1;
        @(posedge clk);
        #1;
        out_ready2 = 1'b0;
        check("valid_clear2", 32'(out_valid2), 32'd0);
        check("in_ready_back2", 32'(in_ready2), 32'd1);
    endtask

    function automatic logic [31:0] rand_word(input int nd);
        logic [31:0] w;
        int unsigned d;
        w = '0;
        for (int i = 0; i < nd; i++) begin
            d = $urandom_range(9, 0);
            if ($urandom_range(7, 0) == 0) d = $urandom_range(15, 10);
            w = w | (32'(d) << (4 * i));
        end
        return w;
    endfunction

    initial begin
        int unsigned spurious;
        logic [31:0] rw;
        rst        = 1'b1;
        in_valid4  = 1'b0;
        out_ready4 = 1'b0;
        bcd4       = '0;
        in_valid2  = 1'b0;
        out_ready2 = 1'b0;
        bcd2       = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready4", 32'(in_ready4), 32'd0);
        check("rst_in_ready2", 32'(in_ready2), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready4", 32'(in_ready4), 32'd1);
        check("post_rst_valid4", 32'(out_valid4), 32'd0);
        check("post_rst_bin4", 32'(bin4), 32'd0);
        check("post_rst_err4", 32'(err4), 32'd0);
        check("post_rst_valid2", 32'(out_valid2), 32'd0);

        send4(16'h0000, 0, 1'b0);
        send4(16'h9999, 0, 1'b0);
        send4(16'h1234, 0, 1'b0);
        send4(16'h12A4, 0, 1'b0);
        send4(16'h0042, 0, 1'b0);
        send4(16'h0507, 5, 1'b1);

        // Reset in the middle of a conversion.
        @(negedge clk);
        bcd4      = 16'h8765;
        in_valid4 = 1'b1;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_in_ready4", 32'(in_ready4), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_valid4", 32'(out_valid4), 32'd0);
        check("midrst_bin4", 32'(bin4), 32'd0);
        check("midrst_err4", 32'(err4), 32'd0);
        check("midrst_ready4", 32'(in_ready4), 32'd1);
        spurious = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid4) spurious++;
        end
        check("midrst_no_valid4", spurious, 32'd0);
        send4(16'h8765, 0, 1'b0);

        for (int k = 0; k < 24; k++) begin
            rw = rand_word(4);
            send4(rw[15:0], $urandom_range(3, 0), 1'($urandom_range(1, 0)));
        end

        send2(8'h99);
        send2(8'h10);
        send2(8'hF0);
        send2(8'h00);
        for (int k = 0; k < 8; k++) begin
            rw = rand_word(2);
            send2(rw[7:0]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "simulation time limit reached");
    end

endmodule
